ext_data_memory: RTL and testbench

Off-chip data memory model behind the CPU's L1 data cache: 512 lines of 256 bits (16 KB), one whole cache line per transfer. It answers each read or write request after a fixed multi-cycle latency with a one-cycle acknowledge. It sits outside the CPU, connected to the cache controller's external-memory port. The cache controller and the bench preload and flush it through its storage array.

---
 rtl/ext_data_memory.sv | 127 ++++++++++++
 tb/tb_ext_data_memory.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_data_memory.sv
// ext_data_memory: off-chip line-wide data memory with a fixed request-to-acknowledge latency.
// Optional build macro EXT_MEM_BOUNDS_CHECK_EN rejects requests with nonzero addr_i[31:14].
//
// state | meaning
// IDLE  | waiting for enable_i with ack_o low; latches the request on acceptance
// BUSY  | counting latency; completes the transfer when the counter reaches LATENCY-1
module ext_data_memory #(
    parameter int DATA_WIDTH = 256,
    parameter int MEM_DEPTH  = 512,
    parameter int LATENCY    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    reg [DATA_WIDTH-1:0] memory [0:MEM_DEPTH-1];

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  oob_q;
    logic                  addr_oob;
    logic                  accept;
    logic                  complete;

`ifdef EXT_MEM_BOUNDS_CHECK_EN
    assign addr_oob = |addr_i[31:5+IDX_W];

    always_ff @(posedge clk_i) begin
        if (accept && addr_oob) begin
            $display("ext_data_memory: warning, out-of-range address 0x%08h", addr_i);
        end
    end
`else
    // Upper address bits are ignored so the line index wraps modulo MEM_DEPTH.
    assign addr_oob = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                // ack_o high blocks acceptance, giving the master one turnaround cycle.
                if (enable_i && !ack_o) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            oob_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            idx_q   <= addr_i[5 +: IDX_W];
            wr_q    <= write_i;
            wdata_q <= data_i;
            oob_q   <= addr_oob;
        end else if (state_q == BUSY && !complete) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Storage has no reset so preloaded contents survive a controller reset.
    always_ff @(posedge clk_i) begin
        if (complete && wr_q && !oob_q) begin
            memory[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o <= complete;
            if (complete && !wr_q) begin
                data_o <= oob_q ? '0 : memory[idx_q];
            end
        end
    end

endmodule

// File: tb/tb_ext_data_memory.sv
// tb_ext_data_memory: randomized self-checking bench for ext_data_memory against a line-array model.
// Honours EXT_MEM_BOUNDS_CHECK_EN when the design is built with it.
module tb_ext_data_memory;

    localparam int DW    = 256;
    localparam int DEPTH = 512;
    localparam int LAT   = 10;
`ifdef EXT_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr;
    logic [DW-1:0] data_in;
    logic          enable;
    logic          write;
    logic          ack;
    logic [DW-1:0] data_out;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;

    always #5 clk = ~clk;

    ext_data_memory #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (data_in),
        .enable_i (enable),
        .write_i  (write),
        .ack_o    (ack),
        .data_o   (data_out)
    );

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit is_oob(input logic [31:0] a);
        return BOUNDS && (a[31:14] != 18'd0);
    endfunction

    // Applies one request to the model; returns what data_o must show after it completes.
    function automatic logic [DW-1:0] model_req(input logic [31:0] a, input logic w,
                                                input logic [DW-1:0] d);
        int idx;
        idx = int'((a >> 5) % DEPTH);
        if (w) begin
            if (!is_oob(a)) ref_mem[idx] = d;
        end else begin
            ref_dout = is_oob(a) ? '0 : ref_mem[idx];
        end
        return ref_dout;
    endfunction

    // Drives one request; lat = negedges from launch to ack (-1 on timeout).
    task automatic do_req(input logic [31:0] a, input logic w, input logic [DW-1:0] d,
                          input bit drop, input bit mutate,
                          output int lat, output logic [DW-1:0] rdata, output logic ack_after);
        int n;
        @(negedge clk);
        addr = a; write = w; data_in = d; enable = 1'b1;
        lat = -1; n = 0; rdata = data_out;
        while (lat < 0 && n < LAT + 20) begin
            @(negedge clk);
            n++;
            if (n == 2 && drop) enable = 1'b0;
            if (n == 3 && mutate) begin
                addr = a ^ 32'h20; data_in = ~d; write = ~w;
            end
            if (ack === 1'b1) begin
                lat = n; rdata = data_out;
            end
        end
        enable = 1'b0;
        @(negedge clk);
        ack_after = ack;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; write = 1'b0; addr = '0; data_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = rand_line();
            dut.memory[i] = ref_mem[i];
        end
        ref_dout = '0;
        repeat (2) @(negedge clk);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        total++;
        if (data_out !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
        rst = 1'b0;
    endtask

    task automatic test_read_latency();
        int lat; logic [DW-1:0] rd, exp; logic aa;
        ref_mem[0] = 256'h5;
        dut.memory[0] = 256'h5;
        exp = model_req(32'h0, 1'b0, '0);
        do_req(32'h0, 1'b0, '0, 1'b0, 1'b0, lat, rd, aa);
        total++;
        if (lat !== LAT + 1) begin bad++; $display("FAIL read_latency: got %0d want %0d", lat, LAT + 1); end
        total++;
        if (rd !== exp) begin bad++; $display("FAIL read_data: got %h want %h", rd, exp); end
        total++;
        if (aa !== 1'b0) begin bad++; $display("FAIL read_ack_width: got %b want 0", aa); end
    endtask

    task automatic test_write();
        int lat; logic [DW-1:0] rd, exp, d; logic aa;
        d = {8{32'hDEADBEEF}};
        exp = model_req(32'h400, 1'b1, d);
        do_req(32'h400, 1'b1, d, 1'b0, 1'b0, lat, rd, aa);
        total++;
        if (lat !== LAT + 1) begin bad++; $display("FAIL write_latency: got %0d want %0d", lat, LAT + 1); end
        total++;
        if (rd !== exp) begin bad++; $display("FAIL write_data_o_held: got %h want %h", rd, exp); end
        total++;
        if (dut.memory[32] !== d) begin bad++; $display("FAIL write_mem32: got %h want %h", dut.memory[32], d); end
        total++;
        if (dut.memory[0] !== 256'h5) begin bad++; $display("FAIL write_mem0: got %h want 5", dut.memory[0]); end
        exp = model_req(32'h400, 1'b0, '0);
        do_req(32'h400, 1'b0, '0, 1'b0, 1'b0, lat, rd, aa);
        total++;
        if (rd !== exp) begin bad++; $display("FAIL write_readback: got %h want %h", rd, exp); end
        total++;
        if (aa !== 1'b0) begin bad++; $display("FAIL write_ack_width: got %b want 0", aa); end
    endtask

    task automatic test_latch_ignore();
        int lat; logic [DW-1:0] rd, exp, d; logic aa;
        d = rand_line();
        exp = model_req(32'd100 << 5, 1'b1, d);
        do_req(32'd100 << 5, 1'b1, d, 1'b0, 1'b1, lat, rd, aa);
        total++;
        if (lat !== LAT + 1) begin bad++; $display("FAIL latch_latency: got %0d want %0d", lat, LAT + 1); end
        total++;
        if (dut.memory[100] !== d) begin bad++; $display("FAIL latch_line: got %h want %h", dut.memory[100], d); end
        total++;
        if (dut.memory[101] !== ref_mem[101]) begin
            bad++; $display("FAIL latch_other_line: got %h want %h", dut.memory[101], ref_mem[101]);
        end
        total++;
        if (rd !== exp) begin bad++; $display("FAIL latch_data_o: got %h want %h", rd, exp); end
    endtask

    task automatic test_back_to_back();
        int n, gap; logic [DW-1:0] exp1, exp2, rd1;
        exp1 = model_req(32'h60, 1'b0, '0);
        @(negedge clk);
        addr = 32'h60; write = 1'b0; enable = 1'b1;
        n = 0; rd1 = '0;
        while (ack !== 1'b1 && n < LAT + 20) begin @(negedge clk); n++; end
        rd1 = data_out;
        total++;
        if (n !== LAT + 1) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", n, LAT + 1); end
        total++;
        if (rd1 !== exp1) begin bad++; $display("FAIL b2b_first_data: got %h want %h", rd1, exp1); end
        addr = 32'h120;
        exp2 = model_req(32'h120, 1'b0, '0);
        gap = 0;
        do begin @(negedge clk); gap++; end while (ack !== 1'b1 && gap < LAT + 20);
        enable = 1'b0;
        total++;
        if (gap !== LAT + 2) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", gap, LAT + 2); end
        total++;
        if (data_out !== exp2) begin bad++; $display("FAIL b2b_second_data: got %h want %h", data_out, exp2); end
        @(negedge clk);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_width: got %b want 0", ack); end
    endtask

    task automatic test_random();
        int lat, mism; logic [DW-1:0] rd, exp, d; logic aa, w; logic [31:0] a;
        for (int it = 0; it < 40; it++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[31:14] = '0;
            w = 1'($urandom_range(1));
            d = rand_line();
            exp = model_req(a, w, d);
            do_req(a, w, d, 1'($urandom_range(1)), 1'($urandom_range(1)), lat, rd, aa);
            total++;
            if (lat !== LAT + 1) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, LAT + 1); end
            total++;
            if (rd !== exp) begin bad++; $display("FAIL rand_data[%0d] addr=%h w=%b: got %h want %h", it, a, w, rd, exp); end
            total++;
            if (aa !== 1'b0) begin bad++; $display("FAIL rand_ack_width[%0d]: got %b want 0", it, aa); end
        end
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.memory[i] !== ref_mem[i]) mism++;
        total++;
        if (mism != 0) begin bad++; $display("FAIL rand_mem_image: got %0d differing lines want 0", mism); end
    endtask

    task automatic test_reset_abort();
        int lat, acks; logic [DW-1:0] rd, exp; logic aa;
        ref_mem[3] = 256'hA5A5;
        dut.memory[3] = 256'hA5A5;
        exp = model_req(32'h60, 1'b0, '0);
        do_req(32'h60, 1'b0, '0, 1'b0, 1'b0, lat, rd, aa);
        total++;
        if (rd !== exp) begin bad++; $display("FAIL abort_preread: got %h want %h", rd, exp); end
        @(negedge clk);
        addr = 32'd7 << 5; write = 1'b1; data_in = ~ref_mem[7]; enable = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        ref_dout = '0;
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL abort_ack: got %b want 0", ack); end
        total++;
        if (data_out !== '0) begin bad++; $display("FAIL abort_data: got %h want 0", data_out); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (LAT + 5) begin @(negedge clk); if (ack !== 1'b0) acks++; end
        total++;
        if (acks != 0) begin bad++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        total++;
        if (dut.memory[7] !== ref_mem[7]) begin
            bad++; $display("FAIL abort_mem7: got %h want %h", dut.memory[7], ref_mem[7]);
        end
    endtask

    task automatic test_bounds();
        int lat; logic [DW-1:0] rd, exp, d, old0, want0; logic aa;
        old0 = ref_mem[0];
        d = rand_line();
        want0 = BOUNDS ? old0 : d;
        exp = model_req(32'h0001_0000, 1'b1, d);
        do_req(32'h0001_0000, 1'b1, d, 1'b0, 1'b0, lat, rd, aa);
        total++;
        if (lat !== LAT + 1) begin bad++; $display("FAIL bounds_wr_latency: got %0d want %0d", lat, LAT + 1); end
        total++;
        if (dut.memory[0] !== want0) begin bad++; $display("FAIL bounds_mem0: got %h want %h", dut.memory[0], want0); end
        exp = model_req(32'h0001_0000, 1'b0, '0);
        do_req(32'h0001_0000, 1'b0, '0, 1'b0, 1'b0, lat, rd, aa);
        total++;
        if (rd !== exp) begin bad++; $display("FAIL bounds_read: got %h want %h", rd, exp); end
        total++;
        if (aa !== 1'b0) begin bad++; $display("FAIL bounds_ack_width: got %b want 0", aa); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write();
        test_latch_ignore();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
